// File: rtl/game_sequencer.sv
// Game-flow controller for the two-player flappy game: IDLE -> COUNTDOWN -> PLAY -> OVER,
// pipe/bird strobes, datapath clear and winner latch. Define SPEEDUP_EN for score-driven pipe speedup.
module game_sequencer #(
    parameter int PIPE_DIV   = 500000,
    parameter int BIRD_DIV   = 3000000,
    parameter int SEC_DIV    = 50000000,
    parameter int COUNT_SECS = 3,
    parameter int OVER_HOLD  = 2,
    parameter int PIPE_STEP  = 50000,
    parameter int PIPE_MIN   = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       jump,
    input  logic       jump2,
    input  logic       hit,
    input  logic       hit2,
    input  logic [7:0] score1,
    input  logic [7:0] score2,
    output logic [1:0] state,
    output logic       run,
    output logic       pipe_tick,
    output logic       bird_tick,
    output logic       clear_game,
    output logic [3:0] countdown,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COUNTDOWN = 2'd1,
        PLAY      = 2'd2,
        OVER      = 2'd3
    } state_t;

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    localparam logic [25:0] BIRD_LAST = 26'(BIRD_DIV - 1);
    localparam logic [25:0] SEC_LAST  = 26'(SEC_DIV - 1);
    localparam logic [25:0] HOLD_LAST = 26'(OVER_HOLD - 1);

    state_t      cur, nxt;
    logic [1:0]  sync_a, sync_b, prev, press;
    logic        press_any;
    logic [25:0] sec_cnt, pipe_cnt, bird_cnt, hold_secs, pipe_div;
    logic        hold_done, rst_pend;
    logic        sec_term, pipe_term, bird_term;
    logic        stay_play, enter_play, leave_over, game_over;

    // Effective pipe period: shrinks by PIPE_STEP per 8 points of the leading score, floored at PIPE_MIN.
    function automatic logic [25:0] speed_div(input logic [7:0] a, input logic [7:0] b);
        logic [31:0] level, cut;
        level = {24'd0, ((a > b) ? a : b) >> 3};
        cut   = level * 32'(PIPE_STEP);
        if (cut + 32'(PIPE_MIN) >= 32'(PIPE_DIV))
            speed_div = 26'(PIPE_MIN);
        else
            speed_div = 26'(32'(PIPE_DIV) - cut);
    endfunction

    assign press_any  = |press;
    assign sec_term   = (sec_cnt == SEC_LAST);
    assign pipe_term  = (pipe_cnt == pipe_div - 26'd1);
    assign bird_term  = (bird_cnt == BIRD_LAST);
    assign game_over  = hit && hit2;
    assign stay_play  = (cur == PLAY) && (nxt == PLAY);
    assign enter_play = (cur == COUNTDOWN) && (nxt == PLAY);
    assign leave_over = (cur == OVER) && (nxt == IDLE);
    assign state      = cur;

    // Buttons are asynchronous and active-low: two sync flops, a history flop, then a registered falling edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_a <= 2'b11;
            sync_b <= 2'b11;
            prev   <= 2'b11;
            press  <= 2'b00;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge value of its neighbour.
            sync_a <= {jump2, jump};
            sync_b <= sync_a;
            prev   <= sync_b;
            press  <= prev & ~sync_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) cur <= IDLE;
        else        cur <= nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns nxt and no latch is inferred.
        nxt = cur;
        case (cur)
            IDLE:      if (press_any) nxt = COUNTDOWN;
            COUNTDOWN: if (sec_term && countdown == 4'd1) nxt = PLAY;
            PLAY:      if (game_over) nxt = OVER;
            OVER:      if (hold_done && press_any) nxt = IDLE;
            default:   nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rst_pend   <= 1'b1;
            clear_game <= 1'b0;
            run        <= 1'b0;
            pipe_tick  <= 1'b0;
            bird_tick  <= 1'b0;
            countdown  <= 4'd0;
            winner     <= 2'b00;
            sec_cnt    <= '0;
            pipe_cnt   <= '0;
            bird_cnt   <= '0;
            hold_secs  <= '0;
            hold_done  <= 1'b0;
        end else begin
            rst_pend   <= 1'b0;
            clear_game <= rst_pend || enter_play || leave_over;
            run        <= (nxt == PLAY);
            // Leaving PLAY clears stay_play, which suppresses a coinciding strobe.
            pipe_tick  <= stay_play && pipe_term;
            bird_tick  <= stay_play && bird_term;

            if (stay_play) begin
                pipe_cnt <= pipe_term ? '0 : pipe_cnt + 26'd1;
                bird_cnt <= bird_term ? '0 : bird_cnt + 26'd1;
            end else begin
                pipe_cnt <= '0;
                bird_cnt <= '0;
            end

            if (cur != nxt || cur == IDLE || cur == PLAY || hold_done)
                sec_cnt <= '0;
            else
                sec_cnt <= sec_term ? '0 : sec_cnt + 26'd1;

            if (cur == IDLE && nxt == COUNTDOWN)
                countdown <= 4'(COUNT_SECS);
            else if (cur == COUNTDOWN && sec_term)
                countdown <= countdown - 4'd1;

            if (cur != OVER) begin
                hold_secs <= '0;
                hold_done <= 1'b0;
            end else if (sec_term && !hold_done) begin
                if (hold_secs == HOLD_LAST) hold_done <= 1'b1;
                else                        hold_secs <= hold_secs + 26'd1;
            end

            if (cur == PLAY && nxt == OVER) begin
                if (score1 > score2)      winner <= 2'b01;
                else if (score2 > score1) winner <= 2'b10;
                else                      winner <= 2'b11;
            end else if (leave_over) begin
                winner <= 2'b00;
            end
        end
    end

    // The divider only changes where a new period starts, so a period in progress is never shortened.
    always_ff @(posedge clk) begin
        if (!reset)
            pipe_div <= 26'(PIPE_DIV);
        else if (SPEEDUP_ON && (enter_play || (stay_play && pipe_term)))
            pipe_div <= speed_div(score1, score2);
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed game flow with randomized players, scores and
// press timing, checked every cycle against a cycle-count model of the game rules.
module tb_game_sequencer;

    localparam int PIPE_DIV   = 4;
    localparam int BIRD_DIV   = 6;
    localparam int SEC_DIV    = 10;
    localparam int COUNT_SECS = 3;
    localparam int OVER_HOLD  = 2;
    localparam int PIPE_STEP  = 1;
    localparam int PIPE_MIN   = 2;

`ifdef SPEEDUP_EN
    localparam bit SPEEDUP_ON = 1'b1;
`else
    localparam bit SPEEDUP_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, jump, jump2, hit, hit2;
    logic [7:0] score1, score2;
    logic [1:0] state;
    logic       run, pipe_tick, bird_tick, clear_game;
    logic [3:0] countdown;
    logic [1:0] winner;

    int passed = 0;
    int total  = 0;

    game_sequencer #(
        .PIPE_DIV(PIPE_DIV), .BIRD_DIV(BIRD_DIV), .SEC_DIV(SEC_DIV), .COUNT_SECS(COUNT_SECS),
        .OVER_HOLD(OVER_HOLD), .PIPE_STEP(PIPE_STEP), .PIPE_MIN(PIPE_MIN)
    ) dut (
        .clk(clk), .reset(reset), .jump(jump), .jump2(jump2), .hit(hit), .hit2(hit2),
        .score1(score1), .score2(score2), .state(state), .run(run), .pipe_tick(pipe_tick),
        .bird_tick(bird_tick), .clear_game(clear_game), .countdown(countdown), .winner(winner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input int st, input int rn, input int pt,
                              input int bt, input int cg, input int cd, input int wn);
        check({tag, ".state"},      32'(state),      32'(st));
        check({tag, ".run"},        32'(run),        32'(rn));
        check({tag, ".pipe_tick"},  32'(pipe_tick),  32'(pt));
        check({tag, ".bird_tick"},  32'(bird_tick),  32'(bt));
        check({tag, ".clear_game"}, 32'(clear_game), 32'(cg));
        check({tag, ".countdown"},  32'(countdown),  32'(cd));
        check({tag, ".winner"},     32'(winner),     32'(wn));
    endtask

    function automatic int model_div(input logic [7:0] a, input logic [7:0] b);
        int lead, d;
        if (!SPEEDUP_ON) return PIPE_DIV;
        lead = (int'(a) > int'(b)) ? int'(a) : int'(b);
        d = PIPE_DIV - PIPE_STEP * (lead / 8);
        return (d < PIPE_MIN) ? PIPE_MIN : d;
    endfunction

    function automatic int model_winner(input logic [7:0] a, input logic [7:0] b);
        if (a > b) return 1;
        if (b > a) return 2;
        return 3;
    endfunction

    // Press a button in IDLE and follow the countdown into PLAY entry (PLAY cycle 0).
    task automatic start_game(input int who);
        if (who == 0) jump = 1'b0; else jump2 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4) check("press_latency.state", 32'(state), 32'd0);
        end
        expect_all("countdown_entry", 1, 0, 0, 0, 0, COUNT_SECS, 0);
        jump  = 1'b1;
        jump2 = 1'b1;
        for (int k = 1; k <= COUNT_SECS * SEC_DIV; k++) begin
            if (k == 3) begin
                if (who == 0) jump2 = 1'b0; else jump = 1'b0;
            end
            if (k == 7) begin
                jump  = 1'b1;
                jump2 = 1'b1;
            end
            tick();
            if (k < COUNT_SECS * SEC_DIV)
                expect_all("countdown", 1, 0, 0, 0, 0, COUNT_SECS - k / SEC_DIV, 0);
            else
                expect_all("play_entry", 2, 1, 0, 0, 1, 0, 0);
        end
    endtask

    // Run PLAY with strobe checks; hit alone from cycle 24, then hit2 at a pipe terminal cycle.
    task automatic play_game(input int min_k, input logic [7:0] f1, input logic [7:0] f2);
        int next_pipe, next_bird, pt, bt;
        bit ended;
        next_pipe = model_div(score1, score2);
        next_bird = BIRD_DIV;
        ended = 1'b0;
        for (int k = 1; k < 200; k++) begin
            tick();
            pt = (k == next_pipe) ? 1 : 0;
            bt = (k == next_bird) ? 1 : 0;
            expect_all("play", 2, 1, pt, bt, 0, 0, 0);
            if (pt == 1) next_pipe = k + model_div(score1, score2);
            if (bt == 1) next_bird = k + BIRD_DIV;
            if (k >= 24) hit = 1'b1;
            if (k >= min_k && next_pipe == k + 1) begin
                hit2   = 1'b1;
                score1 = f1;
                score2 = f2;
                tick();
                expect_all("over_entry", 3, 0, 0, 0, 0, 0, model_winner(f1, f2));
                hit    = 1'b0;
                hit2   = 1'b0;
                ended  = 1'b1;
                break;
            end
        end
        check("play_end_reached", 32'(ended), 32'd1);
    endtask

    // OVER: a jump2 press detected in cycle ign_d is discarded, a jump press detected in acc_d exits.
    task automatic over_phase(input int ign_d, input int acc_d, input int wexp);
        for (int c = 0; c <= acc_d; c++) begin
            if (c == ign_d - 3) jump2 = 1'b0;
            if (c == ign_d - 1) jump2 = 1'b1;
            if (c == acc_d - 3) jump  = 1'b0;
            tick();
            if (c + 1 <= acc_d)
                expect_all("over_hold", 3, 0, 0, 0, 0, 0, wexp);
            else
                expect_all("over_exit", 0, 0, 0, 0, 1, 0, 0);
        end
        jump  = 1'b1;
        jump2 = 1'b1;
        tick();
        expect_all("idle_after_over", 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        int who, m;
        logic [7:0] f1, f2;
        reset  = 1'b0;
        jump   = 1'b1;
        jump2  = 1'b1;
        hit    = 1'b0;
        hit2   = 1'b0;
        score1 = 8'd0;
        score2 = 8'd0;

        repeat (3) tick();
        expect_all("reset", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        expect_all("reset_release", 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_no_press.state", 32'(state), 32'd0);
            check("idle_no_press.clear", 32'(clear_game), 32'd0);
        end

        // Game 1: scores 7/9 -> player 2, ignored press at hold cycle 15, accepted at the boundary 20.
        who = int'($urandom_range(0, 1));
        start_game(who);
        play_game(26, 8'd7, 8'd9);
        over_phase(15, 20, 2);

        // Game 2: high lead score during play (speedup clamp when enabled), tie 5/5, press at 19 discarded.
        score1 = 8'd40;
        score2 = 8'd3;
        start_game(1 - who);
        play_game(30, 8'd5, 8'd5);
        over_phase(19, 23, 3);

        // Game 3: random play scores, final scores and accept time.
        score1 = 8'($urandom_range(0, 60));
        score2 = 8'($urandom_range(0, 60));
        f1 = 8'($urandom_range(0, 255));
        f2 = ($urandom_range(0, 3) == 0) ? f1 : 8'($urandom_range(0, 255));
        start_game(int'($urandom_range(0, 1)));
        play_game(int'($urandom_range(26, 40)), f1, f2);
        over_phase(15, int'($urandom_range(20, 25)), model_winner(f1, f2));

        // Reset in the middle of a countdown.
        jump = 1'b0;
        repeat (4) tick();
        check("reset_test_countdown.state", 32'(state), 32'd1);
        jump = 1'b1;
        m = int'($urandom_range(1, 25));
        repeat (m) tick();
        reset = 1'b0;
        tick();
        expect_all("reset_mid_countdown", 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        expect_all("reset_mid_release", 0, 0, 0, 0, 1, 0, 0);
        tick();
        expect_all("reset_mid_after", 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Top-level game-flow controller for the two-player flappy game. It owns the IDLE → COUNTDOWN → PLAY → OVER sequence and generates the single-cycle pipe-scroll and bird-physics strobes that the pipe and bird datapaths advance on. It issues a clear pulse so those datapaths restart together, and latches the winner for the game-over screen. It sits between the raw jump buttons / hit flags / scores and the pipe, bird and display logic.

## Interface
- PIPE_DIV, 500000: clk cycles between pipe_tick strobes (≥2).
- BIRD_DIV, 3000000: clk cycles between bird_tick strobes (≥2).
- SEC_DIV, 50000000: clk cycles per countdown/hold second (≥2).
- COUNT_SECS, 3: countdown start value (1..9).
- OVER_HOLD, 2: seconds in OVER during which jumps are ignored (≥1).
- PIPE_STEP, 50000: PIPE_DIV reduction per speed level (SPEEDUP_EN only).
- PIPE_MIN, 200000: floor on the effective pipe divider (SPEEDUP_EN only).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- jump  in  1  player-1 button, active-low, asynchronous to clk
- jump2  in  1  player-2 button, active-low, asynchronous to clk
- hit  in  1  player-1 crashed flag
- hit2  in  1  player-2 crashed flag
- score1  in  8  player-1 score
- score2  in  8  player-2 score
- state  out  2  current state: 0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 OVER
- run  out  1  high only while in PLAY
- pipe_tick  out  1  one-cycle pipe-advance strobe
- bird_tick  out  1  one-cycle bird-update strobe
- clear_game  out  1  one-cycle strobe telling the datapaths to reinitialise
- countdown  out  4  seconds remaining in COUNTDOWN; 0 in all other states
- winner  out  2  latched result: 01 player 1, 10 player 2, 11 tie, 00 none

## Operation
- Each of jump and jump2 passes through a 2-flop synchronizer, then a registered previous-value flop.
- A press is a synchronized 1→0 transition. press_any = press1 | press2.
- IDLE:
  - All strobes are 0.
  - press_any moves to COUNTDOWN, loads countdown=COUNT_SECS and clears the second counter.
- COUNTDOWN:
  - The second counter counts 0..SEC_DIV-1. At terminal count, countdown decrements.
  - When countdown would reach 0, the block enters PLAY instead and clear_game pulses for exactly that transition cycle.
  - Jumps are ignored.
- PLAY:
  - The pipe and bird counters start from 0 on entry. Each counts 0..DIV-1 and wraps.
  - Each strobe fires the cycle after its counter's terminal count.
  - hit && hit2 high in the same sampled cycle moves to OVER.
  - On that transition winner latches from score1/score2 sampled in the same cycle: greater score wins, equal scores give 11.
- OVER:
  - Strobes stop and winner holds.
  - The second counter runs for OVER_HOLD seconds. Presses during the hold are discarded.
  - After the hold, press_any moves to IDLE, clears winner to 00 and pulses clear_game.
- Priority in PLAY: reset > OVER transition > strobes. A strobe whose terminal count coincides with the OVER transition is suppressed.
- Reset mid-operation, on the next edge with reset=0:
  - state=IDLE and all counters are 0.
  - Synchronizer flops go to 1 (released).
  - clear_game pulses one cycle after reset deasserts.
- Counters are 26 bits and unsigned, with no overflow past DIV-1.

## Timing
- Reset values: state=0, run=0, pipe_tick=0, bird_tick=0, clear_game=0, countdown=0, winner=00.
- Press latency: jump low at the input changes state on the 4th rising edge (2 sync + 1 edge detect + 1 state register).
- All outputs are registered; state and run change on the same edge.
- First pipe_tick is high in cycle PIPE_DIV after entering PLAY (PLAY entry cycle = cycle 0).
- Subsequent pipe_tick strobes are every PIPE_DIV cycles. bird_tick follows the same rule with BIRD_DIV.
- COUNTDOWN lasts exactly COUNT_SECS·SEC_DIV cycles.
- The OVER hold lasts exactly OVER_HOLD·SEC_DIV cycles. The first accepted press is one detected in the first cycle after the hold.
- hit/hit2 are sampled directly (same clock domain) and take effect on the next edge.

## Configuration
- SPEEDUP_EN defined:
  - level = max(score1,score2)>>3.
  - The effective pipe divider is max(PIPE_MIN, PIPE_DIV − PIPE_STEP·level).
  - It is recomputed and latched only on pipe_tick cycles and on PLAY entry, so a period already in progress is never shortened.
- SPEEDUP_EN undefined: the pipe divider is fixed at PIPE_DIV; PIPE_STEP and PIPE_MIN are unused.

## Test plan
All scenarios use PIPE_DIV=4, BIRD_DIV=6, SEC_DIV=10, COUNT_SECS=3, OVER_HOLD=2.
- Reset low for 3 cycles, then high → all outputs 0, state=0, clear_game pulse 1 cycle after release. Jumps held high for 100 cycles → state stays 0.
- jump low at cycle t → state=1 at edge t+4 with countdown=3. countdown goes 2, 1 at +10 and +20. state=2 with clear_game=1 at +30, countdown=0.
- In PLAY for 24 cycles → pipe_tick high at cycles 4, 8, 12, 16, 20, 24 and bird_tick at 6, 12, 18, 24. At cycle 12 both strobes fire together.
- hit=1 alone → stays in PLAY. Then hit2=1 with score1=7, score2=9 at a pipe-counter terminal cycle → state=3, winner=10, no pipe_tick that cycle. Repeat with equal scores 5/5 → winner=11.
- In OVER, press at hold cycle 15 → ignored. Press after cycle 20 → state=0, winner=00, clear_game pulse. Reset asserted mid-COUNTDOWN → state=0 next edge.
- SPEEDUP_EN with PIPE_STEP=1, PIPE_MIN=2, score1=16 → pipe divider 2 after the next pipe_tick. score1=40 → divider clamps at 2. Without the macro → divider stays 4.
